pifo_node_nway: RTL and testbench

Parametrised PIFO tree node: one resident entry per subtree for `FANOUT` subtrees, plus registered push/pop commands to `FANOUT` child nodes. It is the next-generation replacement for the fixed 4-way node and generalises fanout. It adds combined push+pop (replace) semantics, full/empty detection, error flagging and a ready handshake that enforces the tree's alternate-cycle pipeline. Nodes chain level-to-level: a parent's `i_pop_data` slice k is child k's `o_pop_data`.

---
 rtl/pifo_pkg.sv | 20 ++
 rtl/pifo_argmin.sv | 40 ++++
 rtl/pifo_node_nway.sv | 169 ++++++++++++++++
 tb/tb_pifo_node_nway.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared constants and width helpers for the PIFO node and its argmin tree.
package pifo_pkg;

    localparam int PRIO_LSB = 0;
    localparam logic [15:0] EMPTY_PRIO = '1;

    function automatic int entry_w(input int mtw, input int ptw);
        return mtw + ptw;
    endfunction

    // Metadata sits directly above the priority field in every packed entry.
    function automatic int meta_lsb(input int ptw);
        return PRIO_LSB + ptw;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pifo_argmin.sv
// Combinational binary comparator tree: lowest-index minimum of N unsigned values.
module pifo_argmin
    import pifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic [N*WIDTH-1:0]    vals,
    output logic [idx_w(N)-1:0]   min_idx,
    output logic [WIDTH-1:0]      min_val
);

    localparam int IW     = idx_w(N);
    localparam int LEVELS = idx_w(N);

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
            localparam int W = N >> gi;
            logic [WIDTH-1:0] val [W];
            logic [IW-1:0]    idx [W];
            for (gj = 0; gj < W; gj++) begin : g_cell
                if (gi == 0) begin : g_leaf
                    assign val[gj] = vals[gj*WIDTH +: WIDTH];
                    assign idx[gj] = IW'(gj);
                end else begin : g_cmp
                    // Right side wins only when strictly smaller, so ties keep the lower index.
                    logic take_right;
                    assign take_right = g_lvl[gi-1].val[2*gj+1] < g_lvl[gi-1].val[2*gj];
                    assign val[gj] = take_right ? g_lvl[gi-1].val[2*gj+1] : g_lvl[gi-1].val[2*gj];
                    assign idx[gj] = take_right ? g_lvl[gi-1].idx[2*gj+1] : g_lvl[gi-1].idx[2*gj];
                end
            end
        end
    endgenerate

    assign min_val = g_lvl[LEVELS].val[0];
    assign min_idx = g_lvl[LEVELS].idx[0];

endmodule

// File: rtl/pifo_node_nway.sv
// N-way PIFO tree node: one resident entry per subtree, registered push/pop/replace
// commands to children, one operation every two cycles.
module pifo_node_nway
    import pifo_pkg::*;
#(
    parameter int FANOUT = 4,
    parameter int PTW    = 16,
    parameter int MTW    = 32,
    parameter int CTW    = 10
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [MTW+PTW-1:0]            i_push_data,
    input  logic                          i_pop,
    output logic [MTW+PTW-1:0]            o_pop_data,
    output logic                          o_ready,
    output logic [MTW+PTW-1:0]            o_result,
    output logic                          o_result_vld,
    output logic                          o_err,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [FANOUT-1:0]             o_push,
    output logic [MTW+PTW-1:0]            o_push_data,
    output logic [FANOUT-1:0]             o_pop,
    input  logic [FANOUT*(MTW+PTW)-1:0]   i_pop_data
);

    localparam int EW   = entry_w(MTW, PTW);
    localparam int IDXW = idx_w(FANOUT);
    localparam int ML   = meta_lsb(PTW);
    localparam logic [PTW-1:0] EMPTY   = '1;
    localparam logic [CTW-1:0] CNT_MAX = '1;

    logic [PTW-1:0]     prio_reg [FANOUT];
    logic [MTW-1:0]     meta_reg [FANOUT];
    logic [CTW-1:0]     cnt_reg  [FANOUT];
    logic               ready_reg, result_vld_reg, err_reg;
    logic [EW-1:0]      result_reg, push_data_reg;
    logic [FANOUT-1:0]  push_reg, pop_reg;

    logic [FANOUT*CTW-1:0] cnt_flat;
    logic [FANOUT*PTW-1:0] prio_flat;
    logic [EW-1:0]         child_entry [FANOUT];
    logic [PTW-1:0]        child_prio  [FANOUT];
    logic [IDXW-1:0]       tgt_idx, head_idx;
    logic [CTW-1:0]        cnt_min;
    logic [PTW-1:0]        head_prio, in_prio;
    logic [EW-1:0]         head_entry, tgt_entry;
    logic                  in_is_empty, accept;

    genvar gi;
    generate
        for (gi = 0; gi < FANOUT; gi++) begin : g_slot
            assign cnt_flat[gi*CTW +: CTW]  = cnt_reg[gi];
            assign prio_flat[gi*PTW +: PTW] = prio_reg[gi];
            assign child_entry[gi]          = i_pop_data[gi*EW +: EW];
            assign child_prio[gi]           = child_entry[gi][PRIO_LSB +: PTW];
        end
    endgenerate

    pifo_argmin #(.WIDTH(CTW), .N(FANOUT)) u_cnt_min (
        .vals    (cnt_flat),
        .min_idx (tgt_idx),
        .min_val (cnt_min)
    );

    pifo_argmin #(.WIDTH(PTW), .N(FANOUT)) u_prio_min (
        .vals    (prio_flat),
        .min_idx (head_idx),
        .min_val (head_prio)
    );

    assign head_entry  = {meta_reg[head_idx], prio_reg[head_idx]};
    assign tgt_entry   = {meta_reg[tgt_idx], prio_reg[tgt_idx]};
    assign in_prio     = i_push_data[PRIO_LSB +: PTW];
    assign in_is_empty = (in_prio == EMPTY);
    assign accept      = ready_reg & (i_push | i_pop);

    // The minimum slot is EMPTY only when all are; the minimum count saturates only when all do.
    assign o_empty     = (head_prio == EMPTY);
    assign o_full      = (cnt_min == CNT_MAX);
    assign o_pop_data  = head_entry;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FANOUT; k++) begin
                prio_reg[k] <= EMPTY;
                meta_reg[k] <= '0;
                cnt_reg[k]  <= '0;
            end
            ready_reg      <= 1'b1;
            result_vld_reg <= 1'b0;
            err_reg        <= 1'b0;
            result_reg     <= '0;
            push_data_reg  <= '0;
            push_reg       <= '0;
            pop_reg        <= '0;
        end else begin
            push_reg       <= '0;
            pop_reg        <= '0;
            result_vld_reg <= 1'b0;
            err_reg        <= 1'b0;
            ready_reg      <= 1'b1;
            if ((i_push || i_pop) && !ready_reg) begin
                err_reg <= 1'b1;
            end else if (accept) begin
                ready_reg <= 1'b0;
                if (i_push && !i_pop) begin
                    if (o_full || in_is_empty) begin
                        err_reg <= 1'b1;
                    end else begin
                        cnt_reg[tgt_idx] <= cnt_min + 1'b1;
                        if (in_prio < prio_reg[tgt_idx]) begin
                            prio_reg[tgt_idx] <= in_prio;
                            meta_reg[tgt_idx] <= i_push_data[ML +: MTW];
                        end
                        if (prio_reg[tgt_idx] != EMPTY) begin
                            push_reg[tgt_idx] <= 1'b1;
                            push_data_reg     <= (in_prio < prio_reg[tgt_idx]) ? tgt_entry : i_push_data;
                        end
                    end
                end else if (!i_push && i_pop) begin
                    if (o_empty) begin
                        err_reg <= 1'b1;
                    end else begin
                        result_reg         <= head_entry;
                        result_vld_reg     <= 1'b1;
                        prio_reg[head_idx] <= child_prio[head_idx];
                        meta_reg[head_idx] <= child_entry[head_idx][ML +: MTW];
                        if (cnt_reg[head_idx] != '0)
                            cnt_reg[head_idx] <= cnt_reg[head_idx] - 1'b1;
                        pop_reg[head_idx]  <= (cnt_reg[head_idx] > 1);
                    end
                end else begin
                    if (in_is_empty) begin
                        err_reg <= 1'b1;
                    end else if (in_prio < head_prio) begin
                        result_reg     <= i_push_data;
                        result_vld_reg <= 1'b1;
                    end else begin
                        result_reg     <= head_entry;
                        result_vld_reg <= 1'b1;
                        if (in_prio <= child_prio[head_idx]) begin
                            prio_reg[head_idx] <= in_prio;
                            meta_reg[head_idx] <= i_push_data[ML +: MTW];
                        end else begin
                            // Child H must absorb the incoming entry via its own replace.
                            prio_reg[head_idx] <= child_prio[head_idx];
                            meta_reg[head_idx] <= child_entry[head_idx][ML +: MTW];
                            push_reg[head_idx] <= 1'b1;
                            pop_reg[head_idx]  <= 1'b1;
                            push_data_reg      <= i_push_data;
                        end
                    end
                end
            end
        end
    end

    assign o_ready      = ready_reg;
    assign o_result     = result_reg;
    assign o_result_vld = result_vld_reg;
    assign o_err        = err_reg;
    assign o_push       = push_reg;
    assign o_push_data  = push_data_reg;
    assign o_pop        = pop_reg;

endmodule

// File: tb/tb_pifo_node_nway.sv
// Directed bench for pifo_node_nway with behavioural child queues and a result scoreboard.
module tb_pifo_node_nway;
    import pifo_pkg::*;

    localparam int FANOUT = 4;
    localparam int PTW    = 16;
    localparam int MTW    = 32;
    localparam int CTW    = 4;
    localparam int EW     = MTW + PTW;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_push = 1'b0;
    logic                  i_pop = 1'b0;
    logic [EW-1:0]         i_push_data = '0;
    logic [EW-1:0]         o_pop_data, o_result, o_push_data;
    logic                  o_ready, o_result_vld, o_err, o_empty, o_full;
    logic [FANOUT-1:0]     o_push, o_pop;
    logic [FANOUT*EW-1:0]  i_pop_data;

    logic [EW-1:0] child_q [FANOUT][$];
    logic [EW-1:0] child_head [FANOUT];
    logic [EW-1:0] sb_q [$];
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    pifo_node_nway #(.FANOUT(FANOUT), .PTW(PTW), .MTW(MTW), .CTW(CTW)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (i_push),
        .i_push_data  (i_push_data),
        .i_pop        (i_pop),
        .o_pop_data   (o_pop_data),
        .o_ready      (o_ready),
        .o_result     (o_result),
        .o_result_vld (o_result_vld),
        .o_err        (o_err),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_push       (o_push),
        .o_push_data  (o_push_data),
        .o_pop        (o_pop),
        .i_pop_data   (i_pop_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [EW-1:0] ent(input logic [15:0] p, input logic [31:0] m);
        return {m, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Child k: unordered store, head is the earliest entry of minimum priority.
    function automatic int min_pos(input int k);
        int best = 0;
        for (int j = 1; j < child_q[k].size(); j++)
            if (child_q[k][j][15:0] < child_q[k][best][15:0]) best = j;
        return best;
    endfunction

    always @(negedge i_clk) begin
        for (int k = 0; k < FANOUT; k++) begin
            if (!i_rst_n) begin
                child_q[k].delete();
            end else begin
                if (o_push[k]) child_q[k].push_back(o_push_data);
                if (o_pop[k] && child_q[k].size() > 0) child_q[k].delete(min_pos(k));
            end
            child_head[k] = (child_q[k].size() > 0) ? child_q[k][min_pos(k)] : ent(EMPTY_PRIO, 32'h0);
        end
    end

    always_comb begin
        i_pop_data = '0;
        for (int k = 0; k < FANOUT; k++) i_pop_data[k*EW +: EW] = child_head[k];
    end

    // Scoreboard: every result pulse must match the oldest expected result.
    always @(negedge i_clk) begin
        if (o_result_vld === 1'b1) begin
            if (sb_q.size() == 0) check("unexpected_result_vld", {63'd0, o_result_vld}, 64'd0);
            else check("result", {16'd0, o_result}, {16'd0, sb_q.pop_front()});
        end
    end

    task automatic op(input logic p, input logic q, input logic [EW-1:0] d);
        @(posedge i_clk); #1;
        i_push = p; i_pop = q; i_push_data = d;
        @(posedge i_clk); #1;
        i_push = 1'b0; i_pop = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic e_err, input logic [3:0] e_push, input logic [3:0] e_pop);
        check({tag, "_err"},   {63'd0, o_err},   {63'd0, e_err});
        check({tag, "_push"},  {60'd0, o_push},  {60'd0, e_push});
        check({tag, "_pop"},   {60'd0, o_pop},   {60'd0, e_pop});
        check({tag, "_ready"}, {63'd0, o_ready}, 64'd0);
    endtask

    logic [15:0] fill_p [4];
    logic [31:0] fill_m [4];
    logic [15:0] drain_p [5];
    logic [31:0] drain_m [5];
    logic [3:0]  drain_pop [5];
    int          n_errs;

    initial begin
        fill_p = '{16'd5, 16'd3, 16'd7, 16'd1};
        fill_m = '{32'hA, 32'hB, 32'hC, 32'hD};
        drain_p = '{16'd3, 16'd4, 16'd5, 16'd7, 16'd9};
        drain_m = '{32'hB, 32'h11, 32'hA, 32'hC, 32'h10};
        drain_pop = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_empty", {63'd0, o_empty}, 64'd1);
        check("rst_full", {63'd0, o_full}, 64'd0);
        check("rst_head", {16'd0, o_pop_data}, {16'd0, ent(16'hFFFF, 32'h0)});
        check("rst_push", {60'd0, o_push}, 64'd0);
        check("rst_vld", {63'd0, o_result_vld}, 64'd0);
        check("rst_err", {63'd0, o_err}, 64'd0);
        i_rst_n = 1'b1;

        // 1. Fill empty slots
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b0, ent(fill_p[i], fill_m[i]));
            $display("push prio=%0d meta=%h", fill_p[i], fill_m[i]);
            chk_out($sformatf("fill%0d", i), 1'b0, 4'b0000, 4'b0000);
        end
        check("fill_head", {16'd0, o_pop_data}, {16'd0, ent(16'd1, 32'hD)});
        check("fill_empty", {63'd0, o_empty}, 64'd0);

        // 2. Push into occupied slot 0
        op(1'b1, 1'b0, ent(16'd2, 32'hE));
        $display("push prio=2 meta=e");
        chk_out("push_occ", 1'b0, 4'b0001, 4'b0000);
        check("push_occ_data", {16'd0, o_push_data}, {16'd0, ent(16'd5, 32'hA)});
        check("push_occ_head", {16'd0, o_pop_data}, {16'd0, ent(16'd1, 32'hD)});

        // 3. Pop the head from slot 3 with count 1
        sb_q.push_back(ent(16'd1, 32'hD));
        op(1'b0, 1'b1, '0);
        $display("pop");
        chk_out("pop", 1'b0, 4'b0000, 4'b0000);
        check("pop_vld", {63'd0, o_result_vld}, 64'd1);
        check("pop_head", {16'd0, o_pop_data}, {16'd0, ent(16'd2, 32'hE)});

        // 4. Replace: bypass, then recursion into child 0
        sb_q.push_back(ent(16'd0, 32'hF));
        op(1'b1, 1'b1, ent(16'd0, 32'hF));
        $display("replace prio=0 meta=f");
        chk_out("rep_bypass", 1'b0, 4'b0000, 4'b0000);
        check("rep_bypass_head", {16'd0, o_pop_data}, {16'd0, ent(16'd2, 32'hE)});

        sb_q.push_back(ent(16'd2, 32'hE));
        op(1'b1, 1'b1, ent(16'd9, 32'h10));
        $display("replace prio=9 meta=10");
        chk_out("rep_child", 1'b0, 4'b0001, 4'b0001);
        check("rep_child_data", {16'd0, o_push_data}, {16'd0, ent(16'd9, 32'h10)});
        check("rep_child_head", {16'd0, o_pop_data}, {16'd0, ent(16'd3, 32'hB)});

        // 5a. Push during the not-ready cycle
        @(posedge i_clk); #1;
        i_push = 1'b1; i_push_data = ent(16'd4, 32'h11);
        @(posedge i_clk); #1;
        chk_out("b2b_first", 1'b0, 4'b0000, 4'b0000);
        i_push_data = ent(16'd8, 32'h99);
        @(posedge i_clk); #1;
        i_push = 1'b0;
        $display("push prio=4 meta=11 then push while busy");
        check("b2b_err", {63'd0, o_err}, 64'd1);
        check("b2b_push", {60'd0, o_push}, 64'd0);
        check("b2b_head", {16'd0, o_pop_data}, {16'd0, ent(16'd3, 32'hB)});

        // Drain everything; order proves the rejected push left no trace
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(ent(drain_p[i], drain_m[i]));
            op(1'b0, 1'b1, '0);
            $display("drain pop %0d", i);
            chk_out($sformatf("drain%0d", i), 1'b0, 4'b0000, drain_pop[i]);
        end
        check("drain_empty", {63'd0, o_empty}, 64'd1);
        check("drain_head", {16'd0, o_pop_data}, {16'd0, ent(16'hFFFF, 32'h0)});

        // 5b. Pop when empty
        op(1'b0, 1'b1, '0);
        $display("pop while empty");
        chk_out("pop_empty", 1'b1, 4'b0000, 4'b0000);
        check("pop_empty_vld", {63'd0, o_result_vld}, 64'd0);

        // 5d. Reserved priority
        op(1'b1, 1'b0, ent(16'hFFFF, 32'h77));
        $display("push prio=ffff");
        chk_out("push_ffff", 1'b1, 4'b0000, 4'b0000);
        check("push_ffff_empty", {63'd0, o_empty}, 64'd1);

        // 5c. Saturate every count at 15
        n_errs = 0;
        for (int i = 0; i < 59; i++) begin
            op(1'b1, 1'b0, ent(16'(100 + i), 32'(i)));
            if (o_err) n_errs++;
        end
        $display("pushed 59 entries");
        check("sat_full_early", {63'd0, o_full}, 64'd0);
        op(1'b1, 1'b0, ent(16'd159, 32'd59));
        if (o_err) n_errs++;
        $display("pushed 60th entry");
        check("sat_errs", 64'(n_errs), 64'd0);
        check("sat_full", {63'd0, o_full}, 64'd1);
        op(1'b1, 1'b0, ent(16'd1, 32'h55));
        $display("push while full");
        chk_out("push_full", 1'b1, 4'b0000, 4'b0000);

        // Replace is allowed while full
        sb_q.push_back(ent(16'd50, 32'h5A));
        op(1'b1, 1'b1, ent(16'd50, 32'h5A));
        $display("replace while full prio=50");
        chk_out("rep_full_bypass", 1'b0, 4'b0000, 4'b0000);
        check("rep_full_head0", {16'd0, o_pop_data}, {16'd0, ent(16'd100, 32'd0)});

        sb_q.push_back(ent(16'd100, 32'd0));
        op(1'b1, 1'b1, ent(16'd500, 32'h1F4));
        $display("replace while full prio=500");
        chk_out("rep_full", 1'b0, 4'b0001, 4'b0001);
        check("rep_full_data", {16'd0, o_push_data}, {16'd0, ent(16'd500, 32'h1F4)});
        check("rep_full_head1", {16'd0, o_pop_data}, {16'd0, ent(16'd101, 32'd1)});

        // 6. Reset in the cycle after an accepted replace
        sb_q.push_back(ent(16'd101, 32'd1));
        op(1'b1, 1'b1, ent(16'd600, 32'h258));
        $display("replace prio=600 then reset");
        chk_out("pre_rst", 1'b0, 4'b0010, 4'b0010);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        check("midrst_push", {60'd0, o_push}, 64'd0);
        check("midrst_pop", {60'd0, o_pop}, 64'd0);
        check("midrst_empty", {63'd0, o_empty}, 64'd1);
        check("midrst_head", {16'd0, o_pop_data}, {16'd0, ent(16'hFFFF, 32'h0)});
        check("midrst_vld", {63'd0, o_result_vld}, 64'd0);
        i_rst_n = 1'b1;
        check("midrst_ready", {63'd0, o_ready}, 64'd1);

        op(1'b1, 1'b0, ent(16'd5, 32'hA));
        $display("push after reset prio=5 meta=a");
        chk_out("post_rst", 1'b0, 4'b0000, 4'b0000);
        check("post_rst_head", {16'd0, o_pop_data}, {16'd0, ent(16'd5, 32'hA)});

        repeat (2) @(posedge i_clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
